riscv_test_monitor: RTL and testbench

- Hardware pass/fail monitor for riscv-tests runs. Sits directly downstream of the Core and consumes its architectural state: pc and gp (x3).
- Detects arrival at the test-termination PC and classifies the result as pass or fail, with the failing test number.
- Also detects global timeout and a livelocked or stalled PC.
- Gives the bench, and later FPGA builds, registered sticky result flags instead of ad-hoc polling in each bench.

---
 rtl/riscv_test_monitor_if.sv | 26 ++
 rtl/riscv_test_monitor.sv | 116 +++++++++++
 tb/tb_riscv_test_monitor.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_test_monitor_if.sv
// Monitor bus: Core architectural state in, sticky result flags out.
// master = the side driving start/pc/gp, slave = the monitor.
interface riscv_test_monitor_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] gp;
    logic            done;
    logic            pass;
    logic            fail;
    logic            timeout;
    logic            stalled;
    logic [XLEN-2:0] fail_code;
    logic [31:0]     cycle_count;

    modport master (
        output start, pc, gp,
        input  done, pass, fail, timeout, stalled, fail_code, cycle_count
    );

    modport slave (
        input  start, pc, gp,
        output done, pass, fail, timeout, stalled, fail_code, cycle_count
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout monitor for riscv-tests runs. Watches pc and gp (x3),
// classifies the end of a test and keeps sticky, registered result flags.
module riscv_test_monitor #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] PASS_PC     = 'h44,
    parameter int              TIMEOUT     = 5000,
    parameter int              STALL_LIMIT = 64
) (
    input logic                 clk,
    input logic                 rst,
    riscv_test_monitor_if.slave mon
);
    // same_cnt only has to reach STALL_LIMIT-1 before the run terminates
    localparam int SW = $clog2(STALL_LIMIT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] prev_pc;
    logic [SW-1:0]   same_cnt;
    logic            first_cyc;   // first RUN cycle: prev_pc is stale, skip compare
    logic [31:0]     cyc_cnt;
    logic            stall_q;
    logic [XLEN-2:0] code_q;

    logic at_pass;
    logic gp_ok;
    logic stall_hit;
    logic cnt_last;

    assign at_pass   = (mon.pc == PASS_PC);
    assign gp_ok     = (mon.gp == XLEN'(1));
    assign stall_hit = !first_cyc && (mon.pc == prev_pc) && (same_cnt == SW'(STALL_LIMIT - 1));
    assign cnt_last  = (cyc_cnt == 32'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state: start restarts from anywhere; in RUN the pass PC outranks
    // stall, which outranks the global cycle budget
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mon.start) state_nxt = S_RUN;
            S_RUN: begin
                if (mon.start)     state_nxt = S_RUN;
                else if (at_pass)  state_nxt = gp_ok ? S_PASS : S_FAIL;
                else if (stall_hit) state_nxt = S_TMO;
                else if (cnt_last) state_nxt = S_TMO;
                else               state_nxt = S_RUN;
            end
            S_PASS, S_FAIL, S_TMO: if (mon.start) state_nxt = S_RUN;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run bookkeeping: cycle counter, stall tracker, captured cause/code.
    // Nothing moves outside RUN, so terminal states hold everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_pc   <= '0;
            same_cnt  <= '0;
            first_cyc <= 1'b0;
            cyc_cnt   <= '0;
            stall_q   <= 1'b0;
            code_q    <= '0;
        end else if (mon.start) begin
            same_cnt  <= '0;
            first_cyc <= 1'b1;
            cyc_cnt   <= '0;
            stall_q   <= 1'b0;
            code_q    <= '0;
        end else if (state == S_RUN) begin
            prev_pc   <= mon.pc;
            first_cyc <= 1'b0;
            if (first_cyc || (mon.pc != prev_pc)) same_cnt <= '0;
            else                                  same_cnt <= same_cnt + 1'b1;
            if (at_pass) begin
                if (!gp_ok) code_q <= mon.gp[XLEN-1:1];
            end else if (stall_hit) begin
                stall_q <= 1'b1;
            end else if (!cnt_last) begin
                cyc_cnt <= cyc_cnt + 32'd1;
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        mon.done        = (state == S_PASS) || (state == S_FAIL) || (state == S_TMO);
        mon.pass        = (state == S_PASS);
        mon.fail        = (state == S_FAIL);
        mon.timeout     = (state == S_TMO);
        mon.stalled     = stall_q;
        mon.fail_code   = code_q;
        mon.cycle_count = cyc_cnt;
    end

    // Result flags stay mutually exclusive and stalled only accompanies timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!mon.stalled || mon.timeout);
            assert (!mon.done || ((32'(mon.pass) + 32'(mon.fail) + 32'(mon.timeout)) == 32'd1));
        end
    end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// Bench for riscv_test_monitor: two instances (default budget and a short
// 50-cycle budget) see the same pc/gp stream and are compared against a
// run-length/first-event model of the expected outcome.
module tb_riscv_test_monitor;
    localparam logic [31:0] PASS_PC = 32'h44;
    localparam int STALL = 64;
    localparam int K_PASS = 0, K_FAIL = 1, K_STALL = 2, K_TMO = 3;

    typedef struct packed {
        logic        done;
        logic        pass;
        logic        fail;
        logic        timeout;
        logic        stalled;
        logic [30:0] fail_code;
        logic [31:0] cycle_count;
    } res_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [31:0] gp;

    riscv_test_monitor_if #(.XLEN(32)) ifa ();
    riscv_test_monitor_if #(.XLEN(32)) ifb ();

    assign ifa.start = start;
    assign ifa.pc    = pc;
    assign ifa.gp    = gp;
    assign ifb.start = start;
    assign ifb.pc    = pc;
    assign ifb.gp    = gp;

    riscv_test_monitor #(.XLEN(32), .PASS_PC(PASS_PC), .TIMEOUT(5000), .STALL_LIMIT(STALL))
        dut_a (.clk(clk), .rst(rst), .mon(ifa));
    riscv_test_monitor #(.XLEN(32), .PASS_PC(PASS_PC), .TIMEOUT(50), .STALL_LIMIT(STALL))
        dut_b (.clk(clk), .rst(rst), .mon(ifb));

    res_t obs [2];
    assign obs[0] = {ifa.done, ifa.pass, ifa.fail, ifa.timeout, ifa.stalled, ifa.fail_code, ifa.cycle_count};
    assign obs[1] = {ifb.done, ifb.pass, ifb.fail, ifb.timeout, ifb.stalled, ifb.fail_code, ifb.cycle_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] pcs  [256];
    logic [31:0] gps  [256];
    res_t        logs [2][256];
    int          m_end  [2];
    int          m_kind [2];
    logic [30:0] m_code [2];

    function automatic logic [31:0] rnd_pc();
        logic [31:0] v;
        v = $urandom & 32'hFFFF_FFFC;
        while (v == PASS_PC) v = $urandom & 32'hFFFF_FFFC;
        return v;
    endfunction

    // First terminating event in the sample stream: pass PC, then a run of
    // STALL+1 identical pcs, then the cycle budget.
    function automatic void run_model(int d, int len);
        int tmo;
        int run;
        tmo = (d == 0) ? 5000 : 50;
        run = 0;
        m_end[d]  = -1;
        m_kind[d] = K_PASS;
        m_code[d] = '0;
        for (int k = 0; k < len; k++) begin
            run = (k > 0 && pcs[k] == pcs[k-1]) ? run + 1 : 1;
            if (pcs[k] == PASS_PC) begin
                m_end[d]  = k;
                m_kind[d] = (gps[k] == 32'd1) ? K_PASS : K_FAIL;
                if (gps[k] != 32'd1) m_code[d] = gps[k][31:1];
                return;
            end
            if (run >= STALL + 1) begin
                m_end[d] = k; m_kind[d] = K_STALL; return;
            end
            if (k == tmo - 1) begin
                m_end[d] = k; m_kind[d] = K_TMO; return;
            end
        end
    endfunction

    // Expected outputs right after sample k has been taken
    function automatic res_t want_at(int d, int k);
        res_t r;
        r = '0;
        if (m_end[d] < 0 || k < m_end[d]) begin
            r.cycle_count = 32'(k + 1);
        end else begin
            r.done        = 1'b1;
            r.cycle_count = 32'(m_end[d]);
            case (m_kind[d])
                K_PASS:  r.pass = 1'b1;
                K_FAIL:  begin r.fail = 1'b1; r.fail_code = m_code[d]; end
                K_STALL: begin r.timeout = 1'b1; r.stalled = 1'b1; end
                default: r.timeout = 1'b1;
            endcase
        end
        return r;
    endfunction

    // Pulse start, then feed pcs/gps[0..len-1], logging both DUTs per sample
    task automatic drive_run(input int len);
        @(negedge clk);
        start = 1'b1; pc = $urandom; gp = $urandom;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < len; k++) begin
            pc = pcs[k]; gp = gps[k];
            @(negedge clk);
            logs[0][k] = obs[0];
            logs[1][k] = obs[1];
        end
        run_model(0, len);
        run_model(1, len);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pc = '0; gp = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== res_t'(0)) begin
                errors++; $display("FAIL reset dut%0d got=%h want=0", d, obs[d]);
            end
        end
        start = 1'b1; pc = PASS_PC; gp = 32'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== res_t'(0)) begin
                errors++; $display("FAIL reset_over_start dut%0d got=%h want=0", d, obs[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_pass();
        for (int k = 0; k < 30; k++) begin
            pcs[k] = 32'(4 * k);
            gps[k] = (k == 17) ? 32'd1 : $urandom;
        end
        drive_run(30);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 30; k++) begin
                checks++;
                if (logs[d][k] !== want_at(d, k)) begin
                    errors++; $display("FAIL pass dut%0d k=%0d got=%h want=%h", d, k, logs[d][k], want_at(d, k));
                end
            end
    endtask

    task automatic test_fail();
        for (int it = 0; it < 3; it++) begin
            int hit;
            hit = $urandom_range(3, 40);
            for (int k = 0; k < 48; k++) begin
                pcs[k] = (k == hit) ? PASS_PC : rnd_pc();
                gps[k] = $urandom;
            end
            gps[hit] = (it == 0) ? 32'd7 : ($urandom | 32'h2);
            drive_run(48);
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 48; k++) begin
                    checks++;
                    if (logs[d][k] !== want_at(d, k)) begin
                        errors++; $display("FAIL fail dut%0d it=%0d k=%0d got=%h want=%h", d, it, k, logs[d][k], want_at(d, k));
                    end
                end
        end
    endtask

    task automatic test_stall_and_timeout();
        // constant pc: long budget stalls at cycle 64, short budget times out at 49
        for (int k = 0; k < 80; k++) begin pcs[k] = 32'h100; gps[k] = $urandom; end
        drive_run(80);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 80; k++) begin
                checks++;
                if (logs[d][k] !== want_at(d, k)) begin
                    errors++; $display("FAIL stall dut%0d k=%0d got=%h want=%h", d, k, logs[d][k], want_at(d, k));
                end
            end
        // incrementing pc never reaching the pass PC
        for (int k = 0; k < 60; k++) begin pcs[k] = 32'h1000 + 32'(4 * k); gps[k] = $urandom; end
        drive_run(60);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 60; k++) begin
                checks++;
                if (logs[d][k] !== want_at(d, k)) begin
                    errors++; $display("FAIL timeout dut%0d k=%0d got=%h want=%h", d, k, logs[d][k], want_at(d, k));
                end
            end
    endtask

    task automatic test_priority_restart();
        res_t w;
        for (int k = 0; k < 50; k++) begin pcs[k] = 32'h200 + 32'(4 * k); gps[k] = $urandom; end
        pcs[49] = PASS_PC; gps[49] = 32'd1;
        drive_run(50);
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 50; k++) begin
                checks++;
                if (logs[d][k] !== want_at(d, k)) begin
                    errors++; $display("FAIL priority dut%0d k=%0d got=%h want=%h", d, k, logs[d][k], want_at(d, k));
                end
            end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; pc = PASS_PC; gp = 32'd1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== res_t'(0)) begin
                errors++; $display("FAIL restart_clear dut%0d got=%h want=0", d, obs[d]);
            end
        end
        @(negedge clk);
        w = '0; w.done = 1'b1; w.pass = 1'b1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== w) begin
                errors++; $display("FAIL restart_run dut%0d got=%h want=%h", d, obs[d], w);
            end
        end
    endtask

    task automatic test_reset_mid();
        res_t w;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            pc = 32'h3000 + 32'(4 * k); gp = $urandom;
            @(negedge clk);
        end
        w = '0; w.cycle_count = 32'd20;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== w) begin
                errors++; $display("FAIL midrun dut%0d got=%h want=%h", d, obs[d], w);
            end
        end
        rst = 1'b1; pc = PASS_PC; gp = 32'd1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== res_t'(0)) begin
                errors++; $display("FAIL midrun_reset dut%0d got=%h want=0", d, obs[d]);
            end
        end
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== res_t'(0)) begin
                errors++; $display("FAIL idle_ignores dut%0d got=%h want=0", d, obs[d]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int          seg;
            logic [31:0] cur;
            seg = 0; cur = '0;
            for (int k = 0; k < 160; k++) begin
                if (seg == 0) begin
                    cur = ($urandom_range(0, 15) == 0) ? PASS_PC : rnd_pc();
                    seg = $urandom_range(1, 80);
                end
                seg--;
                pcs[k] = cur;
                gps[k] = ($urandom_range(0, 2) == 0) ? 32'd1 : $urandom;
            end
            drive_run(160);
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < 160; k++) begin
                    checks++;
                    if (logs[d][k] !== want_at(d, k)) begin
                        errors++; $display("FAIL random dut%0d it=%0d k=%0d got=%h want=%h", d, it, k, logs[d][k], want_at(d, k));
                    end
                end
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_stall_and_timeout();
        test_priority_restart();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
